// File: rtl/commu_s_pkg.sv
// commu_s_spi_rx shared types and constants.
// FSM state encoding, default command bytes, frame byte indexes.
`timescale 1ns/1ps
package commu_s_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR_H,
        ADDR_L,
        DATA,
        IGNORE
    } state_t;

    localparam logic [7:0] CMD_WR_DEF = 8'h5A;
    localparam logic [7:0] CMD_RD_DEF = 8'hA5;

    // Frame byte index: CMD first, DATA after the two address bytes,
    // DONE once a full data byte has been received.
    localparam logic [2:0] BYTE_CMD  = 3'd0;
    localparam logic [2:0] BYTE_DATA = 3'd3;
    localparam logic [2:0] BYTE_DONE = 3'd4;

    localparam logic [2:0] BIT_LAST = 3'd7;

endpackage

// File: rtl/commu_s_spi_shift.sv
// Oversampled SPI mode-0 slave bit layer: synchronisers, edge detect,
// rx byte assembly and a loadable tx shift register for MISO.
`timescale 1ns/1ps
module commu_s_spi_shift
    import commu_s_pkg::*;
#(
    parameter int SYNC_STG = 2
) (
    input  logic       clk_sys,
    input  logic       rst,
    input  logic       spi_csn,
    input  logic       spi_sck,
    input  logic       spi_mosi,
    input  logic       tx_load,
    input  logic [7:0] tx_data,
    output logic       byte_vld,
    output logic [7:0] byte_data,
    output logic       byte_fall,
    output logic       frame_start,
    output logic       frame_end,
    output logic       spi_miso
);

    logic [SYNC_STG-1:0] csn_sync;
    logic [SYNC_STG-1:0] sck_sync;
    logic [SYNC_STG-1:0] mosi_sync;
    logic                csn_s;
    logic                sck_s;
    logic                mosi_s;
    logic                csn_d;
    logic                sck_d;
    logic                sck_rise;
    logic                sck_fall;
    logic [2:0]          bit_cnt;
    logic [7:0]          rx_sr;
    logic [7:0]          tx_sr;

    assign csn_s  = csn_sync[SYNC_STG-1];
    assign sck_s  = sck_sync[SYNC_STG-1];
    assign mosi_s = mosi_sync[SYNC_STG-1];

    // csn_d gates the sck edges so a rise seen together with csn rising
    // still completes its byte.
    assign sck_rise  = sck_s & ~sck_d & ~csn_d;
    assign sck_fall  = ~sck_s & sck_d & ~csn_d;
    assign byte_fall = sck_fall & (bit_cnt == 3'd0);
    assign spi_miso  = tx_sr[7];

    // Input synchronisers and one-cycle history for edge detection.
    // csn resets low so a reset inside a frame does not fake a csn fall.
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            csn_sync  <= '0;
            sck_sync  <= '0;
            mosi_sync <= '0;
            csn_d     <= 1'b0;
            sck_d     <= 1'b0;
        end else begin
            csn_sync  <= {csn_sync[SYNC_STG-2:0], spi_csn};
            sck_sync  <= {sck_sync[SYNC_STG-2:0], spi_sck};
            mosi_sync <= {mosi_sync[SYNC_STG-2:0], spi_mosi};
            csn_d     <= csn_s;
            sck_d     <= sck_s;
        end
    end

    // Registered frame edges, aligned with byte_vld timing.
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
        end else begin
            frame_start <= ~csn_s & csn_d;
            frame_end   <= csn_s & ~csn_d;
        end
    end

    // MOSI capture on sck rise; byte_vld on the 8th rise.
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            bit_cnt   <= '0;
            rx_sr     <= '0;
            byte_vld  <= 1'b0;
            byte_data <= '0;
        end else begin
            byte_vld <= 1'b0;
            if (sck_rise) begin
                rx_sr   <= {rx_sr[6:0], mosi_s};
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == BIT_LAST) begin
                    byte_vld  <= 1'b1;
                    byte_data <= {rx_sr[6:0], mosi_s};
                end
            end else if (csn_s | csn_d) begin
                bit_cnt <= '0;
            end
        end
    end

    // MISO shifter: byte-boundary falls never shift, only reload.
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            tx_sr <= '0;
        end else if (tx_load) begin
            tx_sr <= tx_data;
        end else if (sck_fall && bit_cnt != 3'd0) begin
            tx_sr <= {tx_sr[6:0], 1'b0};
        end
    end

endmodule

// File: rtl/commu_s_spi_rx.sv
// ARM->FPGA SPI command slave: decodes CMD/ADDR/DATA frames into fx bus
// writes and reads. SPI_BURST_EN enables auto-increment multi-byte bursts.
`timescale 1ns/1ps
module commu_s_spi_rx
    import commu_s_pkg::*;
#(
    parameter logic [7:0] CMD_WR   = CMD_WR_DEF,
    parameter logic [7:0] CMD_RD   = CMD_RD_DEF,
    parameter int         SYNC_STG = 2
) (
    input  logic        clk_sys,
    input  logic        rst,
    input  logic        spi_csn,
    input  logic        spi_sck,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic        fx_wr,
    output logic [15:0] fx_waddr,
    output logic [7:0]  fx_data,
    output logic        fx_rd,
    output logic [15:0] fx_raddr,
    input  logic [7:0]  fx_q,
    output logic        err_cmd,
    output logic        frm_done
);

    logic        byte_vld;
    logic [7:0]  byte_data;
    logic        byte_fall;
    logic        frame_start;
    logic        frame_end;
    logic        tx_load;
    logic [7:0]  tx_data;

    state_t      state;
    logic        wr_frm;
    logic [7:0]  addr_h;
    logic [15:0] addr;
    logic [2:0]  byte_idx;
    logic        rd_tag;
    logic        cap_pend;
    logic        cap_tag;
    logic        tx_pend;
`ifdef SPI_BURST_EN
    logic [7:0]  pf_buf;
`endif

    commu_s_spi_shift #(
        .SYNC_STG(SYNC_STG)
    ) u_shift (
        .clk_sys    (clk_sys),
        .rst        (rst),
        .spi_csn    (spi_csn),
        .spi_sck    (spi_sck),
        .spi_mosi   (spi_mosi),
        .tx_load    (tx_load),
        .tx_data    (tx_data),
        .byte_vld   (byte_vld),
        .byte_data  (byte_data),
        .byte_fall  (byte_fall),
        .frame_start(frame_start),
        .frame_end  (frame_end),
        .spi_miso   (spi_miso)
    );

    // MISO source select: clear on frame edges, read data on capture,
    // next byte (or zero) on the boundary fall after a read byte.
    always_comb begin
        tx_load = 1'b0;
        tx_data = '0;
        if (frame_start || frame_end) begin
            tx_load = 1'b1;
        end else if (cap_pend && cap_tag && state == DATA) begin
            tx_load = 1'b1;
            tx_data = fx_q;
        end else if (byte_fall && tx_pend) begin
            tx_load = 1'b1;
`ifdef SPI_BURST_EN
            tx_data = pf_buf;
`endif
        end
    end

    // Frame FSM and fx bus strobes.
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            wr_frm   <= 1'b0;
            addr_h   <= '0;
            addr     <= '0;
            byte_idx <= BYTE_CMD;
            rd_tag   <= 1'b0;
            cap_pend <= 1'b0;
            cap_tag  <= 1'b0;
            tx_pend  <= 1'b0;
            fx_wr    <= 1'b0;
            fx_waddr <= '0;
            fx_data  <= '0;
            fx_rd    <= 1'b0;
            fx_raddr <= '0;
            err_cmd  <= 1'b0;
            frm_done <= 1'b0;
`ifdef SPI_BURST_EN
            pf_buf   <= '0;
`endif
        end else begin
            fx_wr    <= 1'b0;
            fx_rd    <= 1'b0;
            err_cmd  <= 1'b0;
            frm_done <= 1'b0;
            cap_pend <= fx_rd;
            cap_tag  <= rd_tag;
            if (frame_start) begin
                state    <= CMD;
                byte_idx <= BYTE_CMD;
                tx_pend  <= 1'b0;
            end else begin
                if (byte_vld) begin
                    if (state != IDLE && state != IGNORE &&
                        byte_idx != BYTE_DONE)
                        byte_idx <= byte_idx + 3'd1;
                    unique case (state)
                        CMD: begin
                            if (byte_data == CMD_WR) begin
                                wr_frm <= 1'b1;
                                state  <= ADDR_H;
                            end else if (byte_data == CMD_RD) begin
                                wr_frm <= 1'b0;
                                state  <= ADDR_H;
                            end else begin
                                err_cmd <= 1'b1;
                                state   <= IGNORE;
                            end
                        end
                        ADDR_H: begin
                            addr_h <= byte_data;
                            state  <= ADDR_L;
                        end
                        ADDR_L: begin
                            addr  <= {addr_h, byte_data};
                            state <= DATA;
                            if (!wr_frm) begin
                                fx_raddr <= {addr_h, byte_data};
                                fx_rd    <= 1'b1;
                                rd_tag   <= 1'b1;
                            end
                        end
                        DATA: begin
                            if (wr_frm) begin
                                fx_waddr <= addr;
                                fx_data  <= byte_data;
                                fx_wr    <= 1'b1;
                                addr     <= addr + 16'd1;
                            end else begin
                                tx_pend <= 1'b1;
                            end
`ifndef SPI_BURST_EN
                            state <= IGNORE;
`endif
                        end
                        default: ;
                    endcase
                end
                if (byte_fall && tx_pend)
                    tx_pend <= 1'b0;
`ifdef SPI_BURST_EN
                if (cap_pend && !cap_tag)
                    pf_buf <= fx_q;
                if (state == DATA && !wr_frm &&
                    ((cap_pend && cap_tag) || (byte_fall && tx_pend))) begin
                    fx_rd    <= 1'b1;
                    rd_tag   <= 1'b0;
                    fx_raddr <= fx_raddr + 16'd1;
                end
`endif
                if (frame_end) begin
                    state    <= IDLE;
                    tx_pend  <= 1'b0;
                    byte_idx <= BYTE_CMD;
                    frm_done <= (byte_idx == BYTE_DONE) ||
                                (byte_vld && state == DATA);
                end
            end
        end
    end

endmodule

// File: tb/tb_commu_s_spi_rx.sv
// Self-checking bench for commu_s_spi_rx: directed and random frames
// compared against a frame-level reference model.
`timescale 1ns/1ps
module tb_commu_s_spi_rx;

    logic        clk_sys = 1'b0;
    logic        rst = 1'b1;
    logic        spi_csn = 1'b1;
    logic        spi_sck = 1'b0;
    logic        spi_mosi = 1'b0;
    logic        spi_miso;
    logic        fx_wr;
    logic [15:0] fx_waddr;
    logic [7:0]  fx_data;
    logic        fx_rd;
    logic [15:0] fx_raddr;
    logic [7:0]  fx_q = 8'h00;
    logic        err_cmd;
    logic        frm_done;

    int n_chk = 0;
    int n_fail = 0;

    int          err_n = 0;
    int          done_n = 0;
    logic [15:0] wr_a[$];
    logic [7:0]  wr_d[$];
    logic [15:0] rd_a[$];

    logic [7:0]  fb[8];
    logic [7:0]  mb[8];
    logic [15:0] exp_wa = 16'h0000;
    logic [7:0]  exp_wd = 8'h00;

    always #5 clk_sys = ~clk_sys;

    commu_s_spi_rx dut (
        .clk_sys (clk_sys),
        .rst     (rst),
        .spi_csn (spi_csn),
        .spi_sck (spi_sck),
        .spi_mosi(spi_mosi),
        .spi_miso(spi_miso),
        .fx_wr   (fx_wr),
        .fx_waddr(fx_waddr),
        .fx_data (fx_data),
        .fx_rd   (fx_rd),
        .fx_raddr(fx_raddr),
        .fx_q    (fx_q),
        .err_cmd (err_cmd),
        .frm_done(frm_done)
    );

    function automatic logic [7:0] mem_val(input logic [15:0] a);
        logic [7:0] t;
        if (a == 16'h0010) return 8'h9E;
        t = a[7:0] * 8'd29;
        return t ^ a[15:8] ^ 8'h3C;
    endfunction

    // Bus slave: read data one clock after the strobe.
    always @(posedge clk_sys)
        if (fx_rd) fx_q <= mem_val(fx_raddr);

    // Bus monitor sampled mid-cycle.
    always @(negedge clk_sys)
        if (!rst) begin
            if (fx_wr) begin
                wr_a.push_back(fx_waddr);
                wr_d.push_back(fx_data);
            end
            if (fx_rd) rd_a.push_back(fx_raddr);
            if (err_cmd) err_n++;
            if (frm_done) done_n++;
        end

    task automatic spi_bits(input logic [7:0] v, input int n,
                            output logic [7:0] r);
        r = '0;
        for (int i = 7; i > 7 - n; i--) begin
            spi_mosi = v[i];
            #40;
            r[i] = spi_miso;
            spi_sck = 1'b1;
            #40;
            spi_sck = 1'b0;
        end
    endtask

    task automatic send_frame(input int nb, input int pb);
        logic [7:0] r;
        @(negedge clk_sys);
        #2;
        spi_csn = 1'b0;
        #80;
        for (int k = 0; k < nb; k++) begin
            spi_bits(fb[k], 8, r);
            mb[k] = r;
        end
        if (pb > 0) spi_bits(fb[nb], pb, r);
        #80;
        spi_csn = 1'b1;
        #300;
    endtask

    task automatic run_frame(input string name, input int nb, input int pb);
        int          wb, rb, eb, db, ndata, nw, expw, nr;
        logic        valid, wr, rdf;
        logic [15:0] a, t;
        logic [7:0]  em;
        wb = wr_a.size();
        rb = rd_a.size();
        eb = err_n;
        db = done_n;
        send_frame(nb, pb);
        valid = (fb[0] == 8'h5A) || (fb[0] == 8'hA5);
        wr    = (fb[0] == 8'h5A);
        rdf   = valid && !wr && nb >= 3;
        a     = {fb[1], fb[2]};
        ndata = (nb > 3) ? nb - 3 : 0;
`ifdef SPI_BURST_EN
        nw = ndata;
`else
        nw = (ndata > 0) ? 1 : 0;
`endif
        expw = (valid && wr) ? nw : 0;
        n_chk++;
        if ((err_n - eb) !== (valid ? 0 : 1)) begin
            n_fail++;
            $display("FAIL %s err_cmd: got %0d want %0d",
                     name, err_n - eb, valid ? 0 : 1);
        end
        n_chk++;
        if ((done_n - db) !== ((valid && ndata > 0) ? 1 : 0)) begin
            n_fail++;
            $display("FAIL %s frm_done: got %0d want %0d",
                     name, done_n - db, (valid && ndata > 0) ? 1 : 0);
        end
        n_chk++;
        if ((wr_a.size() - wb) !== expw) begin
            n_fail++;
            $display("FAIL %s fx_wr count: got %0d want %0d",
                     name, wr_a.size() - wb, expw);
        end
        for (int i = 0; i < expw; i++) begin
            if (wb + i < wr_a.size()) begin
                t = a + 16'(i);
                n_chk++;
                if (wr_a[wb+i] !== t || wr_d[wb+i] !== fb[3+i]) begin
                    n_fail++;
                    $display("FAIL %s write %0d: got %h/%h want %h/%h",
                             name, i, wr_a[wb+i], wr_d[wb+i], t, fb[3+i]);
                end
            end
        end
        if (expw > 0) begin
            exp_wa = a + 16'(expw - 1);
            exp_wd = fb[3+expw-1];
        end
        nr = rd_a.size() - rb;
        n_chk++;
`ifdef SPI_BURST_EN
        if (rdf ? (nr < 1) : (nr != 0)) begin
`else
        if (nr !== (rdf ? 1 : 0)) begin
`endif
            n_fail++;
            $display("FAIL %s fx_rd count: got %0d want %0d",
                     name, nr, rdf ? 1 : 0);
        end
        if (rdf && nr > 0) begin
            n_chk++;
            if (rd_a[rb] !== a) begin
                n_fail++;
                $display("FAIL %s fx_raddr: got %h want %h",
                         name, rd_a[rb], a);
            end
        end
        for (int k = 0; k < nb; k++) begin
            em = 8'h00;
            t  = a + 16'(k - 3);
`ifdef SPI_BURST_EN
            if (rdf && k >= 3) em = mem_val(t);
`else
            if (rdf && k == 3) em = mem_val(t);
`endif
            n_chk++;
            if (mb[k] !== em) begin
                n_fail++;
                $display("FAIL %s miso byte %0d: got %h want %h",
                         name, k, mb[k], em);
            end
        end
        n_chk++;
        if (fx_waddr !== exp_wa || fx_data !== exp_wd) begin
            n_fail++;
            $display("FAIL %s write hold: got %h/%h want %h/%h",
                     name, fx_waddr, fx_data, exp_wa, exp_wd);
        end
        n_chk++;
        if (spi_miso !== 1'b0) begin
            n_fail++;
            $display("FAIL %s idle miso: got %b want 0", name, spi_miso);
        end
    endtask

    task automatic set_fb(input logic [7:0] b0, b1, b2, b3, b4, b5);
        fb[0] = b0; fb[1] = b1; fb[2] = b2;
        fb[3] = b3; fb[4] = b4; fb[5] = b5;
        fb[6] = 8'h00; fb[7] = 8'h00;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (4) @(negedge clk_sys);
        n_chk++;
        if ({fx_wr, fx_rd, err_cmd, frm_done, spi_miso} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset strobes: got %b want 00000",
                     {fx_wr, fx_rd, err_cmd, frm_done, spi_miso});
        end
        n_chk++;
        if (fx_waddr !== 16'h0 || fx_raddr !== 16'h0 || fx_data !== 8'h0)
        begin
            n_fail++;
            $display("FAIL reset regs: got %h %h %h want 0",
                     fx_waddr, fx_raddr, fx_data);
        end
        rst = 1'b0;
        repeat (10) @(negedge clk_sys);
    endtask

    task automatic test_write;
        set_fb(8'h5A, 8'h12, 8'h34, 8'hC3, 8'h00, 8'h00);
        run_frame("write", 4, 0);
    endtask

    task automatic test_read;
        set_fb(8'hA5, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00);
        run_frame("read", 4, 0);
    endtask

    task automatic test_bad_cmd;
        set_fb(8'h00, 8'h12, 8'h34, 8'h56, 8'h00, 8'h00);
        run_frame("bad_cmd", 4, 0);
        set_fb(8'h5A, 8'h0A, 8'hBC, 8'h5D, 8'h00, 8'h00);
        run_frame("after_bad", 4, 0);
    endtask

    task automatic test_partial;
        set_fb(8'h5A, 8'h12, 8'h34, 8'hE7, 8'h00, 8'h00);
        run_frame("partial", 3, 5);
        set_fb(8'h5A, 8'h00, 8'h01, 8'h7F, 8'h00, 8'h00);
        run_frame("after_partial", 4, 0);
    endtask

    task automatic test_burst;
        set_fb(8'h5A, 8'hFF, 8'hFE, 8'h11, 8'h22, 8'h33);
        run_frame("burst_wr", 6, 0);
        set_fb(8'hA5, 8'hFF, 8'hFE, 8'h00, 8'h00, 8'h00);
        run_frame("burst_rd", 6, 0);
    endtask

    task automatic test_back_to_back;
        set_fb(8'h5A, 8'hA0, 8'h55, 8'h96, 8'h00, 8'h00);
        run_frame("b2b_wr", 4, 0);
        set_fb(8'hA5, 8'h12, 8'h34, 8'h00, 8'h00, 8'h00);
        run_frame("b2b_rd", 4, 0);
    endtask

    task automatic test_reset_mid;
        logic [7:0] r;
        int         rb, db;
        rb = rd_a.size();
        db = done_n;
        @(negedge clk_sys);
        #2;
        spi_csn = 1'b0;
        #80;
        spi_bits(8'hA5, 8, r);
        spi_bits(8'h00, 8, r);
        spi_bits(8'h10, 4, r);
        #10;
        rst = 1'b1;
        @(negedge clk_sys);
        @(negedge clk_sys);
        n_chk++;
        if ({fx_wr, fx_rd, err_cmd, frm_done, spi_miso} !== 5'b0) begin
            n_fail++;
            $display("FAIL mid_reset strobes: got %b want 00000",
                     {fx_wr, fx_rd, err_cmd, frm_done, spi_miso});
        end
        n_chk++;
        if (fx_waddr !== 16'h0 || fx_raddr !== 16'h0 || fx_data !== 8'h0)
        begin
            n_fail++;
            $display("FAIL mid_reset regs: got %h %h %h want 0",
                     fx_waddr, fx_raddr, fx_data);
        end
        #2;
        rst = 1'b0;
        exp_wa = 16'h0000;
        exp_wd = 8'h00;
        #20;
        spi_bits(8'h00, 4, r);
        spi_bits(8'h00, 8, r);
        #80;
        spi_csn = 1'b1;
        #300;
        n_chk++;
        if ((rd_a.size() - rb) !== 0 || (done_n - db) !== 0) begin
            n_fail++;
            $display("FAIL mid_reset aborted frame: rd %0d done %0d want 0 0",
                     rd_a.size() - rb, done_n - db);
        end
        n_chk++;
        if (r !== 8'h00) begin
            n_fail++;
            $display("FAIL mid_reset miso: got %h want 00", r);
        end
        set_fb(8'hA5, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00);
        run_frame("read_after_reset", 4, 0);
    endtask

    task automatic test_random;
        int nb, pb, sel;
        for (int f = 0; f < 10; f++) begin
            for (int k = 0; k < 8; k++) fb[k] = 8'($urandom);
            sel = $urandom_range(0, 9);
            if (sel < 4)      fb[0] = 8'h5A;
            else if (sel < 8) fb[0] = 8'hA5;
            nb = $urandom_range(1, 6);
            pb = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
            run_frame($sformatf("rand%0d", f), nb, pb);
        end
    endtask

    initial begin
        test_reset;
        test_write;
        test_read;
        test_bad_cmd;
        test_partial;
        test_burst;
        test_back_to_back;
        test_reset_mid;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
